// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//   Baccarat-style dealing sequencer. Requests cards from a deck, issues one
//   load strobe per card received, applies the third-card drawing rules and
//   registers the win lights when the round resolves.
//
//   Optional build macro: DEAL_TIMEOUT_EN
//     defined   -> a deal state that waits TIMEOUT_CYCLES cycles without a
//                  card aborts the round to IDLE and raises timeout_err.
//     undefined -> deal states wait forever; timeout_err is tied to 0.
//
//   Ports
//     slow_clock        in   sole clock, rising edge
//     reset             in   synchronous, active-high
//     start             in   begin a round (honoured in IDLE/RESULT only)
//     card_valid        in   deck has a card (only looked at while card_req)
//     pscore, dscore    in   [3:0] hand scores 0-9 from the scorer
//     pcard3            in   [3:0] raw player third card code 1-13
//     card_req          out  card wanted (deal states only)
//     load_pcard1..3,
//     load_dcard1..3    out  one-cycle load strobes, at most one high
//     busy              out  high outside IDLE and RESULT
//     player_win_light,
//     dealer_win_light  out  result lights (both lit on a tie)
//     timeout_err       out  round aborted by a card-wait timeout
// ---------------------------------------------------------------------------
module game_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       start,
    input  logic       card_valid,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       card_req,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       busy,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_P1, S_D1, S_P2, S_D2, S_EVAL,
        S_P3, S_PW, S_D3, S_DW, S_RESULT
    } state_t;

    state_t     state, next_state;
    logic       is_deal;
    logic       to_hit;
    logic       start_ok;
    logic [3:0] v;

    // Dealer third-card rule, keyed on the dealer score and the player's
    // third-card value.
    function automatic logic dealer_draws(input logic [3:0] d, input logic [3:0] cv);
        logic r;
        r = 1'b0;
        case (d)
            4'd0, 4'd1, 4'd2: r = 1'b1;
            4'd3:             r = (cv != 4'd8);
            4'd4:             r = (cv >= 4'd2) && (cv <= 4'd7);
            4'd5:             r = (cv >= 4'd4) && (cv <= 4'd7);
            4'd6:             r = (cv >= 4'd6) && (cv <= 4'd7);
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    // Face cards and tens count as zero.
    assign v = (pcard3 <= 4'd9) ? pcard3 : 4'd0;

    assign is_deal  = (state == S_P1) || (state == S_D1) || (state == S_P2) ||
                      (state == S_D2) || (state == S_P3) || (state == S_D3);
    assign busy     = (state != S_IDLE) && (state != S_RESULT);
    assign start_ok = start && !busy;

`ifdef DEAL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          terr_q;

    // The cycle in which the counter would reach the limit is the last
    // waiting cycle; the abort takes effect on that edge.
    assign to_hit = is_deal && !card_valid && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge slow_clock) begin
        if (reset)
            wait_cnt <= '0;
        else if (next_state != state)
            wait_cnt <= '0;
        else if (is_deal && !card_valid)
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge slow_clock) begin
        if (reset)
            terr_q <= 1'b0;
        else if (to_hit)
            terr_q <= 1'b1;
        else if (start_ok)
            terr_q <= 1'b0;
    end

    assign timeout_err = terr_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge slow_clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_P1;
            S_P1:     if (card_valid) next_state = S_D1;
            S_D1:     if (card_valid) next_state = S_P2;
            S_P2:     if (card_valid) next_state = S_D2;
            S_D2:     if (card_valid) next_state = S_EVAL;
            S_EVAL: begin
                if (pscore >= 4'd8 || dscore >= 4'd8)
                    next_state = S_RESULT;
                else if (pscore <= 4'd5)
                    next_state = S_P3;
                else if (dscore <= 4'd5)
                    next_state = S_D3;
                else
                    next_state = S_RESULT;
            end
            S_P3:     if (card_valid) next_state = S_PW;
            S_PW:     next_state = dealer_draws(dscore, v) ? S_D3 : S_RESULT;
            S_D3:     if (card_valid) next_state = S_DW;
            S_DW:     next_state = S_RESULT;
            S_RESULT: if (start) next_state = S_P1;
            default:  next_state = S_IDLE;
        endcase
        if (to_hit)
            next_state = S_IDLE;
    end

    // Mealy strobes; gated by reset so nothing leaks out while a reset is
    // pending in the middle of a handshake.
    always_comb begin
        card_req    = is_deal && !reset;
        load_pcard1 = (state == S_P1) && card_valid && !reset;
        load_dcard1 = (state == S_D1) && card_valid && !reset;
        load_pcard2 = (state == S_P2) && card_valid && !reset;
        load_dcard2 = (state == S_D2) && card_valid && !reset;
        load_pcard3 = (state == S_P3) && card_valid && !reset;
        load_dcard3 = (state == S_D3) && card_valid && !reset;
    end

    // Lights capture the scores on the edge that enters RESULT and then hold.
    always_ff @(posedge slow_clock) begin
        if (reset || to_hit || start_ok) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (next_state == S_RESULT && state != S_RESULT) begin
            player_win_light <= (pscore >= dscore);
            dealer_win_light <= (dscore >= pscore);
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b1, start = 1'b0, card_valid = 1'b0;
    logic [3:0] pscore = '0, dscore = '0, pcard3 = 4'd1;
    logic       card_req, busy, player_win_light, dealer_win_light, timeout_err;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [5:0] sv;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];          // event codes: 1..6 strobes, 10+ result/abort
    bit prev_busy = 1'b0;

    always #5 slow_clock = ~slow_clock;

    game_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .slow_clock(slow_clock), .reset(reset), .start(start),
        .card_valid(card_valid), .pscore(pscore), .dscore(dscore),
        .pcard3(pcard3), .card_req(card_req),
        .load_pcard1(load_pcard1), .load_pcard2(load_pcard2),
        .load_pcard3(load_pcard3), .load_dcard1(load_dcard1),
        .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
        .busy(busy), .player_win_light(player_win_light),
        .dealer_win_light(dealer_win_light), .timeout_err(timeout_err)
    );

    assign sv = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: outcome of a round from the game rules. p1/d1 are the
    // scores after the player's / dealer's third card.
    function automatic int model_round(input int p0, d0, c3, p1, d1);
        int pf, df, cv;
        bit draw;
        pf = p0; df = d0;
        exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(4);
        if (p0 < 8 && d0 < 8) begin
            if (p0 <= 5) begin
                exp_q.push_back(5);
                pf = p1;
                cv = (c3 > 9) ? 0 : c3;
                draw = (d0 <= 2) ||
                       (d0 == 3 && cv != 8) ||
                       (d0 == 4 && cv >= 2 && cv <= 7) ||
                       (d0 == 5 && cv >= 4 && cv <= 7) ||
                       (d0 == 6 && cv >= 6 && cv <= 7);
                if (draw) begin
                    exp_q.push_back(6);
                    df = d1;
                end
            end else if (d0 <= 5) begin
                exp_q.push_back(6);
                df = d1;
            end
        end
        model_round = 10 + 2 * int'(pf >= df) + int'(df >= pf);
        exp_q.push_back(model_round);
    endfunction

    // Monitor: pops the scoreboard on every strobe and every busy->idle drop.
    always @(negedge slow_clock) begin
        int code, e;
        if (reset) begin
            chk("reset_outputs", {card_req, sv}, 0);
            prev_busy = 1'b0;
        end else begin
            code = 0;
            if (sv != 0) begin
                chk("strobe_onehot", $countones(sv), 1);
                for (int i = 5; i >= 0; i--) if (sv[i]) code = i + 1;
            end else if (prev_busy && !busy) begin
                code = 10 + 2 * player_win_light + dealer_win_light + 4 * timeout_err;
            end
            if (code != 0) begin
                if (exp_q.size() == 0)
                    chk("unexpected_event", code, -1);
                else begin
                    e = exp_q.pop_front();
                    chk(code < 10 ? "strobe_order" : "round_result", code, e);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic run_round(input int p0, d0, c3, p1, d1, vprob, stall_after);
        int  res, cards, stall_left;
        bit  upd_p, upd_d, done, stalling;
        res = model_round(p0, d0, c3, p1, d1);
        cards = 0; stall_left = 10; upd_p = 0; upd_d = 0; done = 0;
        @(posedge slow_clock); #1;
        pscore = 4'(p0); dscore = 4'(d0); pcard3 = 4'(c3);
        start = 1'b1; card_valid = 1'($urandom_range(0, 1));
        @(posedge slow_clock); #1;
        start = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            if (upd_p) pscore = 4'(p1);
            if (upd_d) dscore = 4'(d1);
            upd_p = 0; upd_d = 0;
            stalling = (cards == stall_after) && (stall_left > 0);
            card_valid = stalling ? 1'b0 : ($urandom_range(0, 99) < vprob);
            start = busy ? ($urandom_range(0, 7) == 0) : 1'b0;
            @(negedge slow_clock);
            if (n == 0) chk("clear_on_start", {player_win_light, dealer_win_light, timeout_err}, 0);
            if (stalling) begin
                chk("stall_card_req", card_req, 1);
                chk("stall_no_strobe", sv, 0);
                stall_left--;
            end
            if (load_pcard3) upd_p = 1;
            if (load_dcard3) upd_d = 1;
            if (sv != 0) cards++;
            if (!busy) done = 1;
            else begin
                @(posedge slow_clock); #1;
            end
        end
        start = 1'b0;
        if (!done) chk("round_timeout_busy", busy, 0);
        // lights must hold in RESULT; card_valid is meaningless here
        card_valid = 1'b1;
        repeat (2) begin
            @(negedge slow_clock);
            chk("lights_hold", 10 + 2 * player_win_light + dealer_win_light, res);
            chk("result_no_req", card_req, 0);
        end
        card_valid = 1'b0;
    endtask

    task automatic reset_in_p3();
        exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(4);
        @(posedge slow_clock); #1;
        pscore = 4'd3; dscore = 4'd2; pcard3 = 4'd5; start = 1'b1; card_valid = 1'b1;
        @(posedge slow_clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge slow_clock); #1; end
        card_valid = 1'b0;                 // now in EVAL
        @(posedge slow_clock); #1;         // now in P3, waiting
        start = 1'b1;                      // must be ignored while busy
        @(negedge slow_clock);
        chk("p3_busy", busy, 1);
        chk("p3_card_req", card_req, 1);
        @(posedge slow_clock); #1;
        start = 1'b0; reset = 1'b1; card_valid = 1'b1;
        @(negedge slow_clock);
        chk("p3_still_after_start", busy, 1);
        chk("rst_card_req", card_req, 0);
        chk("rst_load_pcard3", load_pcard3, 0);
        @(posedge slow_clock); #1;
        reset = 1'b0; card_valid = 1'b0;
        @(negedge slow_clock);
        chk("rst_idle_outputs",
            {busy, card_req, sv, player_win_light, dealer_win_light, timeout_err}, 0);
    endtask

`ifdef DEAL_TIMEOUT_EN
    task automatic timeout_in_p2();
        int waits;
        bit gone;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(14);
        @(posedge slow_clock); #1;
        start = 1'b1; card_valid = 1'b1;
        @(posedge slow_clock); #1;
        start = 1'b0;
        @(posedge slow_clock); #1;
        @(posedge slow_clock); #1;
        card_valid = 1'b0;                 // P2 with no card
        waits = 0; gone = 0;
        for (int n = 0; n < 40 && !gone; n++) begin
            @(negedge slow_clock);
            if (busy && card_req) waits++;
            if (!busy) gone = 1;
            else begin @(posedge slow_clock); #1; end
        end
        chk("timeout_wait_cycles", waits, 16);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_lights", {player_win_light, dealer_win_light}, 0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge slow_clock);
        #1 reset = 1'b0;
        @(negedge slow_clock);
        chk("post_reset_state",
            {busy, card_req, player_win_light, dealer_win_light, timeout_err}, 0);

        run_round(8, 3, 5, 8, 3, 100, -1);   // player natural
        run_round(4, 3, 8, 6, 3, 100, -1);   // player draws, dealer 3 vs 8 stands
        run_round(4, 4, 12, 4, 9, 100, -1);  // face card -> v=0, dealer stands, tie
        run_round(7, 6, 1, 7, 6, 100, 1);    // stall 10 cycles in D1
        run_round(6, 2, 1, 6, 9, 80, -1);    // player stands, dealer draws
        run_round(2, 9, 3, 5, 1, 80, -1);    // dealer natural
        reset_in_p3();
`ifdef DEAL_TIMEOUT_EN
        timeout_in_p2();
`endif
        for (int r = 0; r < 40; r++)
            run_round($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 13),
                      $urandom_range(0, 9), $urandom_range(0, 9),
                      $urandom_range(60, 100), -1);

        repeat (3) @(negedge slow_clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 255; card-wait limit in cycles, used only when DEAL_TIMEOUT_EN is defined.
- REQ-002: slow_clock  in  1  sole clock; all state changes on its rising edge.
- REQ-003: reset  in  1  synchronous, active-high reset.
- REQ-004: start  in  1  begin a round; sampled only in IDLE or RESULT.
- REQ-005: card_valid  in  1  card available from the deck; meaningful only while card_req=1.
- REQ-006: pscore  in  4  player hand score, 0-9, registered by the downstream scorer.
- REQ-007: dscore  in  4  dealer hand score, 0-9, registered by the downstream scorer.
- REQ-008: pcard3  in  4  player third card, raw code 1-13.
- REQ-009: card_req  out  1  request a card from the deck.
- REQ-010: load_pcard1/2/3, load_dcard1/2/3  out  1 each  one-cycle load strobes; at most one is high in any cycle.
- REQ-011: busy  out  1  high in every state except IDLE and RESULT.
- REQ-012: player_win_light, dealer_win_light  out  1 each  result lights.
- REQ-013: timeout_err  out  1  set when a round is aborted on a card-wait timeout.

Function
- REQ-014: States: IDLE, P1, D1, P2, D2, EVAL, P3, PW, D3, DW, RESULT.
- REQ-015: Deal states are P1, D1, P2, D2, P3 and D3; card_req=1 only in these states.
- REQ-016: In a deal state with card_valid=1, the matching load strobe is high in that same cycle (Mealy), and the state advances on the next edge.
- REQ-017: In a deal state with card_valid=0, the block holds state and asserts no load strobe.
- REQ-018: Deal order from IDLE on start=1: P1 -> D1 -> P2 -> D2 -> EVAL.
- REQ-019: EVAL lasts one cycle, is entered one cycle after the load_dcard2 strobe, and samples pscore and dscore.
- REQ-020: From EVAL, natural: if pscore>=8 or dscore>=8, go to RESULT.
- REQ-021: From EVAL, otherwise: if pscore<=5, go to P3.
- REQ-022: From EVAL, otherwise (player stands): if dscore<=5, go to D3; else go to RESULT.
- REQ-023: P3 -> PW; PW is a one-cycle wait so that pcard3 and the scores are updated.
- REQ-024: In PW, the card value v = pcard3 if pcard3<=9, else v = 0.
- REQ-025: From PW, the dealer draws (go to D3) when: dscore 0-2; dscore 3 and v!=8; dscore 4 and v in 2-7; dscore 5 and v in 4-7; dscore 6 and v in 6-7.
- REQ-026: From PW, in every other case (including dscore 7), go to RESULT.
- REQ-027: D3 -> DW, a one-cycle wait, then -> RESULT.
- REQ-028: On entry to RESULT, the lights are registered from pscore and dscore: pscore>dscore lights player only; dscore>pscore lights dealer only; a tie lights both.
- REQ-029: Lights hold through RESULT.
- REQ-030: In RESULT, start=1 clears both lights and timeout_err and goes to P1 on the next edge.
- REQ-031: start is ignored while busy=1.
- REQ-032: card_valid is ignored in any state that is not a deal state.

Reset
- REQ-033: reset=1 at an edge forces IDLE and clears both lights, timeout_err and any wait counter; it takes priority over every other input.
- REQ-034: While reset is applied, card_req and all load strobes are 0, including when reset occurs mid-round or mid-handshake.

Configuration
- REQ-035: Macro DEAL_TIMEOUT_EN defined: the wait counter clears on entry to each deal state and increments each cycle that card_req=1 and card_valid=0.
- REQ-036: With DEAL_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block goes to IDLE, sets timeout_err=1 and clears both lights.
- REQ-037: With DEAL_TIMEOUT_EN defined, timeout_err is cleared by reset or by the next start.
- REQ-038: DEAL_TIMEOUT_EN not defined: a deal state waits for card_valid indefinitely, timeout_err is constant 0, and no counter is built.

Verification
- REQ-039: card_valid held 1, start pulse, pscore=8, dscore=3 at EVAL -> strobes P1,D1,P2,D2 in 4 consecutive cycles; no third card; player_win_light=1 only.
- REQ-040: pscore=4, dscore=3 at EVAL, pcard3=8 -> load_pcard3 fires, load_dcard3 never fires, then RESULT.
- REQ-041: pscore=4, dscore=4 at EVAL, pcard3=12 (v=0) -> dealer stands; pscore=dscore=4 at RESULT -> both lights=1.
- REQ-042: card_valid=0 for 10 cycles in D1 -> state held, card_req=1 throughout, no strobes; card_valid=1 -> single load_dcard1.
- REQ-043: reset=1 asserted during P3 -> next cycle IDLE, all outputs 0; start ignored while busy.
- REQ-044: With DEAL_TIMEOUT_EN and TIMEOUT_CYCLES=16, card_valid=0 in P2 -> abort to IDLE with timeout_err=1 after 16 waiting cycles.
